// File: rtl/uart_tx_arbiter_if.sv
// Bus between the UART TX arbiter and its surroundings: requester-side
// request/data/ack/done, transmitter-side start strobe/data/busy, and the
// arbiter's state for debug (IDLE=0, START=1, BUSY=2, FIN=3).
//
// Handshake: a requester holds req[i] with a valid byte on slice i; the
// arbiter samples req only while idle and answers with a one-cycle ack[i]
// when it latches the byte, and a one-cycle done[i] when the transmitter
// has finished shifting it out. Toward the transmitter, tx_ready is a
// level-held start strobe that drops the cycle after tx_busy is seen high.
interface uart_tx_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    localparam int GW = $clog2(N);

    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic [N-1:0]    done;
    logic [GW-1:0]   grant_id;
    logic            tx_ready;
    logic [DW-1:0]   tx_data;
    logic            tx_busy;
    logic            timeout_err;
    logic [1:0]      state;

    // Requesters plus transmitter: drive requests and busy, observe the rest.
    modport master (
        output req, req_data, tx_busy,
        input  ack, done, grant_id, tx_ready, tx_data, timeout_err, state
    );

    // The arbiter itself.
    modport slave (
        input  req, req_data, tx_busy,
        output ack, done, grant_id, tx_ready, tx_data, timeout_err, state
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte requesters.
// Latches the winner's byte, strobes the transmitter, follows its busy flag,
// and reports per-requester ack/done. A start that never sees tx_busy rise
// is abandoned after START_TIMEOUT cycles with a timeout_err pulse.
module uart_tx_arbiter #(
    parameter int N             = 4,
    parameter int DW            = 8,
    parameter int START_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            clr,
    uart_tx_arbiter_if.slave bus
);
    localparam int GW = $clog2(N);
    localparam int CW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t        state;
    logic [GW-1:0] ptr;
    logic [GW-1:0] cand;
    logic [GW-1:0] win_idx;
    logic          win_found;
    logic [CW-1:0] cnt;

    assign bus.state = state;

    // Winner search: first set req bit strictly after the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = GW'((int'(ptr) + k) % N);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Arbitration FSM; all bus outputs are registered here.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state           <= S_IDLE;
            ptr             <= GW'(N - 1);
            cnt             <= '0;
            bus.ack         <= '0;
            bus.done        <= '0;
            bus.grant_id    <= '0;
            bus.tx_ready    <= 1'b0;
            bus.tx_data     <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            // Pulse outputs default low so each lasts exactly one cycle.
            bus.ack         <= '0;
            bus.done        <= '0;
            bus.timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        bus.tx_data  <= bus.req_data[win_idx*DW +: DW];
                        bus.grant_id <= win_idx;
                        bus.ack      <= N'(1) << win_idx;
                        bus.tx_ready <= 1'b1;
                        cnt          <= '0;
                        state        <= S_START;
                    end
                end
                S_START: begin
                    // Busy on the final count still wins over the timeout.
                    if (bus.tx_busy) begin
                        bus.tx_ready <= 1'b0;
                        state        <= S_BUSY;
                    end else if (cnt == CW'(START_TIMEOUT - 1)) begin
                        bus.tx_ready    <= 1'b0;
                        bus.timeout_err <= 1'b1;
                        ptr             <= bus.grant_id;
                        state           <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BUSY: begin
                    if (!bus.tx_busy) begin
                        bus.done <= N'(1) << bus.grant_id;
                        ptr      <= bus.grant_id;
                        state    <= S_FIN;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a round-robin reference model
// predicts grant order into a scoreboard queue; a monitor pops and compares
// on every ack, done and timeout pulse. A small UART model answers tx_ready.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int TMO = 16;

    typedef struct {
        int          id;
        logic [DW-1:0] data;
        bit          tmo;
    } item_t;

    logic clk = 1'b0;
    logic clr = 1'b1;

    uart_tx_arbiter_if #(.N(N), .DW(DW)) bus ();

    uart_tx_arbiter #(.N(N), .DW(DW), .START_TIMEOUT(TMO)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    item_t       exp_q[$];
    item_t       pend_q[$];
    item_t       it;
    int          checks = 0;
    int          failures = 0;
    int          ack_cnt = 0;
    int          done_cnt = 0;
    int          tmo_cnt = 0;
    int          model_ptr = N - 1;
    int          round_base = 0;
    int          ready_run = 0;
    int          last_run = 0;
    bit          prev_ready = 1'b0;
    bit          prev_busy = 1'b0;
    bit          uart_en = 1'b0;
    int          busy_dly = 1;
    int          busy_len = 3;
    logic [DW-1:0] data_arr [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference rule: first requesting index after ptr, wrapping modulo N.
    function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Drive a request mask (held for n grants) and queue the predicted grants.
    task automatic issue(input logic [N-1:0] mask, input int n, input bit tmo);
        int p;
        int w;
        round_base = ack_cnt;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = data_arr[i];
        p = model_ptr;
        for (int g = 0; g < n; g++) begin
            w = rr_pick(mask, p);
            exp_q.push_back('{id: w, data: data_arr[w], tmo: tmo});
            p = w;
        end
        model_ptr = p;
        bus.req = mask;
    endtask

    task automatic finish_round(input int n);
        int c;
        c = 0;
        while (c < 2000 && ack_cnt < round_base + n) begin
            @(negedge clk);
            c++;
        end
        check("ack_wait", 32'(ack_cnt >= round_base + n), 32'd1);
        bus.req = '0;
        c = 0;
        while (c < 400 && (pend_q.size() != 0 || exp_q.size() != 0 || bus.tx_ready || bus.tx_busy)) begin
            @(negedge clk);
            c++;
        end
        check("round_drain", 32'(c < 400), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // UART model: after tx_ready is seen, wait busy_dly cycles, then hold
    // tx_busy for busy_len cycles. Reset by clr, silent when disabled.
    initial begin
        int phase;
        int cnt;
        phase = 0;
        cnt = 0;
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (clr || !uart_en) begin
                bus.tx_busy = 1'b0;
                phase = 0;
            end else begin
                case (phase)
                    0: if (bus.tx_ready) begin
                        cnt = busy_dly;
                        phase = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt <= 0) begin
                            bus.tx_busy = 1'b1;
                            cnt = busy_len;
                            phase = 2;
                        end
                    end
                    default: begin
                        cnt--;
                        if (cnt <= 0) begin
                            bus.tx_busy = 1'b0;
                            phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: compare every ack/done/timeout pulse against the scoreboard.
    always @(negedge clk) begin
        if (clr) begin
            ready_run = 0;
            prev_ready = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (bus.ack != '0) begin
                ack_cnt++;
                check("ack_expected", 32'(exp_q.size() > 0), 32'd1);
                check("ack_after_done", 32'(pend_q.size()), 32'd0);
                check("ack_with_done", 32'(bus.done), 32'd0);
                if (exp_q.size() > 0) begin
                    it = exp_q.pop_front();
                    check("ack_bit", 32'(bus.ack), 32'd1 << it.id);
                    check("ack_grant_id", 32'(bus.grant_id), 32'(it.id));
                    check("ack_tx_data", 32'(bus.tx_data), 32'(it.data));
                    check("ack_tx_ready", 32'(bus.tx_ready), 32'd1);
                    pend_q.push_back(it);
                end
            end
            if (bus.done != '0) begin
                done_cnt++;
                check("done_expected", 32'(pend_q.size() > 0), 32'd1);
                if (pend_q.size() > 0) begin
                    it = pend_q.pop_front();
                    check("done_bit", 32'(bus.done), 32'd1 << it.id);
                    check("done_not_timeout", 32'(it.tmo), 32'd0);
                    check("done_tx_data_hold", 32'(bus.tx_data), 32'(it.data));
                end
            end
            if (bus.timeout_err) begin
                tmo_cnt++;
                check("timeout_expected", 32'(pend_q.size() > 0), 32'd1);
                if (pend_q.size() > 0) begin
                    it = pend_q.pop_front();
                    check("timeout_item", 32'(it.tmo), 32'd1);
                end
            end
            if (prev_ready && prev_busy) check("ready_drop_on_busy", 32'(bus.tx_ready), 32'd0);
            if (bus.tx_ready) begin
                ready_run++;
            end else if (ready_run != 0) begin
                last_run = ready_run;
                ready_run = 0;
            end
            prev_ready = bus.tx_ready;
            prev_busy = bus.tx_busy;
        end
    end

    // Stimulus: directed scenarios then a randomized soak.
    initial begin
        int base_ack;
        int base_done;
        int base_tmo;
        int c;
        int n;
        bus.req = '0;
        bus.req_data = '0;

        // Reset with all requesters active.
        data_arr[0] = 8'h5a; data_arr[1] = 8'h6b; data_arr[2] = 8'h7c; data_arr[3] = 8'h8d;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = data_arr[i];
        bus.req = 4'b1111;
        clr = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("rst_timeout", 32'(bus.timeout_err), 32'd0);
        check("rst_state", 32'(bus.state), 32'd0);
        uart_en = 1'b1;
        busy_dly = 1;
        busy_len = 3;
        issue(4'b1111, 1, 1'b0);
        clr = 1'b0;
        finish_round(1);

        // Single requester, long frame.
        data_arr[2] = 8'ha5;
        busy_dly = 2;
        busy_len = 20;
        issue(4'b0100, 1, 1'b0);
        finish_round(1);
        check("single_grant_id", 32'(bus.grant_id), 32'd2);
        check("single_tx_data_hold", 32'(bus.tx_data), 32'ha5);

        // Move the pointer to 3, then all four held: 11,22,33,44,11.
        busy_dly = 1;
        busy_len = 3;
        issue(4'b1000, 1, 1'b0);
        finish_round(1);
        data_arr[0] = 8'h11; data_arr[1] = 8'h22; data_arr[2] = 8'h33; data_arr[3] = 8'h44;
        issue(4'b1111, 5, 1'b0);
        finish_round(5);

        // Stalled transmitter: tx_busy never rises.
        uart_en = 1'b0;
        base_done = done_cnt;
        base_tmo = tmo_cnt;
        issue(4'b0010, 1, 1'b1);
        finish_round(1);
        check("timeout_ready_cycles", 32'(last_run), 32'(TMO));
        check("timeout_pulses", 32'(tmo_cnt - base_tmo), 32'd1);
        check("timeout_no_done", 32'(done_cnt - base_done), 32'd0);
        uart_en = 1'b1;
        issue(4'b0011, 1, 1'b0);
        finish_round(1);
        check("after_timeout_grant", 32'(bus.grant_id), 32'd0);

        // Reset in the middle of a frame.
        busy_dly = 1;
        busy_len = 20;
        issue(4'b0100, 1, 1'b0);
        c = 0;
        while (c < 100 && !(bus.tx_busy && !bus.tx_ready && pend_q.size() != 0)) begin
            @(negedge clk);
            c++;
        end
        check("reach_busy", 32'(c < 100), 32'd1);
        bus.req = '0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        check("midrst_tx_ready", 32'(bus.tx_ready), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_ack", 32'(bus.ack), 32'd0);
        exp_q.delete();
        pend_q.delete();
        model_ptr = N - 1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        busy_len = 3;
        issue(4'b1000, 1, 1'b0);
        finish_round(1);
        check("midrst_regrant", 32'(bus.grant_id), 32'd3);

        // Random soak.
        base_ack = ack_cnt;
        base_done = done_cnt;
        for (int r = 0; r < 50; r++) begin
            for (int i = 0; i < N; i++) data_arr[i] = DW'($urandom_range(7, 30000));
            busy_dly = $urandom_range(1, 3);
            busy_len = $urandom_range(1, 6);
            n = $urandom_range(1, 3);
            issue(N'($urandom_range(1, 15)), n, 1'b0);
            finish_round(n);
        end
        check("soak_ack_eq_done", 32'(ack_cnt - base_ack), 32'(done_cnt - base_done));
        check("soak_queue_empty", 32'(exp_q.size() + pend_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter among N byte requesters.
- Latches the winning requester's byte and drives the transmitter's start strobe (tx_ready) and data (tx_data).
- Tracks the transmitter's busy flag and reports per-requester ack (byte accepted) and done (byte shifted out).
- Sits between on-chip byte producers and the UART TX core, with a start-timeout guard against a stalled transmitter.

Parameters:
- N, 4: number of requesters (2..8).
- DW, 8: data width per requester and of tx_data.
- START_TIMEOUT, 16: max cycles tx_ready is held without tx_busy rising.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- req  in  N  per-requester request level; bit i means byte on req_data slice i is valid.
- req_data  in  N*DW  requester i data at bits [i*DW +: DW].
- ack  out  N  one-cycle pulse on the granted bit when its byte is latched.
- done  out  N  one-cycle pulse on the granted bit when its transmission completes.
- grant_id  out  $clog2(N)  index of current/last granted requester.
- tx_ready  out  1  start strobe to UART TX, level-held until tx_busy seen.
- tx_data  out  DW  byte to transmit, stable from grant until next grant.
- tx_busy  in  1  UART TX shifting a frame.
- timeout_err  out  1  one-cycle pulse when a start attempt times out.

Behaviour:
- Reset (clr=1, async, effective immediately):
  - ack, done, tx_ready, tx_data, grant_id, timeout_err all 0; state IDLE; timeout counter 0.
  - Round-robin pointer = N-1, so requester 0 has first priority.
- States: IDLE, START, BUSY, FIN.
- IDLE, any req bit set at an edge:
  - Winner = first set bit searching from pointer+1 upward, wrapping mod N.
  - At that same edge: tx_data <= winner's slice; grant_id <= winner; ack[winner] <= 1; tx_ready <= 1; counter <= 0; go to START.
  - ack and tx_ready are therefore visible 1 cycle after req is sampled.
- START:
  - ack returns to 0 after one cycle.
  - tx_busy=1 sampled: tx_ready <= 0; go to BUSY.
  - Otherwise counter increments. When counter reaches START_TIMEOUT-1 with tx_busy still 0: tx_ready <= 0; timeout_err pulses 1 cycle; pointer <= grant_id; go to IDLE. No done pulse.
  - tx_busy rising on the same edge as the final count: busy wins, no timeout.
- BUSY: wait for tx_busy=0 sampled; then done[grant_id] <= 1 for one cycle; pointer <= grant_id; go to FIN.
- FIN: one idle cycle (done deasserts), then IDLE. Minimum spacing between grants is 1 cycle after done.
- req is sampled only in IDLE:
  - Dropping req after ack has no effect; the latched byte is still sent.
  - A continuously held req is re-served only after every other pending requester.
- tx_data and grant_id hold their value after completion until the next grant.
- Only one bit of ack/done is ever high; never both ack and done in the same cycle.
- clr asserted mid-frame: tx_ready drops immediately; no done is issued. The UART core is reset by the same clr.

Test Plan:
- Reset: clr=1 for 3 cycles with req=4'b1111 → all outputs 0, no ack. Release → ack=4'b0001, tx_data=req_data[7:0], tx_ready=1 one cycle later.
- Single requester: req=4'b0100, data 8'hA5; model raises tx_busy 2 cycles after tx_ready for 20 cycles → ack[2] one cycle; tx_ready low the cycle after busy is seen; done[2] one cycle after busy falls; grant_id=2.
- All four held with bytes 11,22,33,44 → tx_data sequence 11,22,33,44,11; each done precedes the next ack; no requester is starved.
- Timeout: req=4'b0010, tx_busy tied 0 → tx_ready high exactly 16 cycles, timeout_err one pulse, no done. Next request with req=4'b0011 grants requester 0 (pointer=1).
- Mid-frame reset: assert clr during BUSY → tx_ready, done, ack 0 same cycle. After release, req=4'b1000 alone is granted with ack[3].
- Random soak (mirroring the UART bench style): 50 rounds of random req masks and data $urandom_range(7,30000) truncated to 8 bits → scoreboard order matches the round-robin model; ack count equals done count.
